// File: rtl/minirisc_pkg.sv
// Shared widths and writeback types for the minirisc core.
package minirisc_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LD  = 1'b1
    } wb_src_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
        logic [NUM_REGS-1:0] one;
        one = {{(NUM_REGS-1){1'b0}}, 1'b1};
        return one << r;
    endfunction

endpackage

// File: rtl/wb_queue.sv
// Small FIFO of pending register writes; exposes every slot so the owner
// can build a pending-register mask.
module wb_queue
    import minirisc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_req_t                  push_data,
    input  logic                     pop,
    output wb_req_t                  head,
    output logic                     head_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output wb_req_t [DEPTH-1:0]      entries,
    output logic [DEPTH-1:0]         entry_valid
);

    localparam int PW = $clog2(DEPTH);

    wb_req_t [DEPTH-1:0] mem;
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic                do_push;
    logic                do_pop;

    assign full       = (count == (PW+1)'(DEPTH));
    assign head_valid = (count != '0);
    assign head       = mem[rd_ptr];
    assign entries    = mem;
    assign do_push    = push & ~full;
    assign do_pop     = pop & head_valid;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        logic [PW-1:0] off;
        off         = '0;
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off            = PW'(i) - rd_ptr;
            entry_valid[i] = ({1'b0, off} < count);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and load writebacks into the single register-file write port,
// round-robin on contention, with a mask of registers that still have writes in flight.
module regfile_wb_arbiter
    import minirisc_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_reg,
    input  logic [DATA_W-1:0]     ld_data,
    output logic                  regWrite,
    output logic [REG_ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0]     writeData,
    output logic [NUM_REGS-1:0]   pend_mask,
    output logic                  idle
);

    localparam int CW = $clog2(QDEPTH) + 1;

    // Handshake: a write transfers at a rising edge where valid && ready.
    // ready depends only on registered occupancy, never on the same-edge pop,
    // and valid is ignored while ready is low (the sender keeps holding it).

    wb_req_t               alu_head, ld_head;
    logic                  alu_hv, ld_hv;
    logic                  alu_full, ld_full;
    logic [CW-1:0]         alu_count, ld_count;
    wb_req_t [QDEPTH-1:0]  alu_entries, ld_entries;
    logic [QDEPTH-1:0]     alu_ev, ld_ev;
    logic                  alu_pop, ld_pop;
    wb_src_e               grant;
    wb_src_e               last_grant;
    logic                  any_head;

    assign alu_ready = ~alu_full;
    assign ld_ready  = ~ld_full;

    wb_queue #(.DEPTH(QDEPTH)) u_alu_q (
        .clk         (clk),
        .rst         (rst),
        .push        (alu_valid & alu_ready),
        .push_data   ({alu_reg, alu_data}),
        .pop         (alu_pop),
        .head        (alu_head),
        .head_valid  (alu_hv),
        .full        (alu_full),
        .count       (alu_count),
        .entries     (alu_entries),
        .entry_valid (alu_ev)
    );

    wb_queue #(.DEPTH(QDEPTH)) u_ld_q (
        .clk         (clk),
        .rst         (rst),
        .push        (ld_valid & ld_ready),
        .push_data   ({ld_reg, ld_data}),
        .pop         (ld_pop),
        .head        (ld_head),
        .head_valid  (ld_hv),
        .full        (ld_full),
        .count       (ld_count),
        .entries     (ld_entries),
        .entry_valid (ld_ev)
    );

    assign any_head = alu_hv | ld_hv;

    always_comb begin
        grant = REQ_ALU;
        if (alu_hv && ld_hv)
            grant = (last_grant == REQ_LD) ? REQ_ALU : REQ_LD;
        else if (ld_hv)
            grant = REQ_LD;
    end

    assign alu_pop = any_head && (grant == REQ_ALU);
    assign ld_pop  = any_head && (grant == REQ_LD);

    always_comb begin
        regWrite  = 1'b0;
        writeReg  = '0;
        writeData = '0;
        if (any_head) begin
            regWrite  = 1'b1;
            writeReg  = (grant == REQ_ALU) ? alu_head.rd   : ld_head.rd;
            writeData = (grant == REQ_ALU) ? alu_head.data : ld_head.data;
        end
    end

    // Reset to the load side so the ALU wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= REQ_LD;
        else if (any_head)
            last_grant <= grant;
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (alu_ev[i]) pend_mask = pend_mask | reg_onehot(alu_entries[i].rd);
            if (ld_ev[i])  pend_mask = pend_mask | reg_onehot(ld_entries[i].rd);
        end
    end

    assign idle = (alu_count == '0) && (ld_count == '0);

endmodule
